// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM-stage data-memory access unit.
package mem_pkg;

  localparam logic [3:0] LD_B  = 4'b0000;
  localparam logic [3:0] LD_H  = 4'b0001;
  localparam logic [3:0] LD_W  = 4'b0010;
  localparam logic [3:0] LD_BU = 4'b0100;
  localparam logic [3:0] LD_HU = 4'b0101;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, WAIT_RD, DONE} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  typedef struct packed {
    logic [NUM_LANES-1:0]      be;
    logic [NUM_LANES-1:0][7:0] wdata;
  } wr_lane_t;

  // Bit 2 only selects signedness, so loads and stores share this decode.
  function automatic size_e size_of(input logic [3:0] op);
    if (op[3])                 return SZ_W;
    else if (op[1:0] == 2'b00) return SZ_B;
    else if (op[1:0] == 2'b01) return SZ_H;
    else                       return SZ_W;
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
    return (sz == SZ_H && off[0]) || (sz == SZ_W && off != 2'b00);
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half lane of a read word and sign/zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [3:0]  ld_op,
  output logic [31:0] result
);

  logic [NUM_LANES-1:0][7:0] lanes;
  logic [7:0]                b;
  logic [15:0]               h;
  logic                      sext;

  assign lanes = rdata;
  assign b     = lanes[offset];
  assign h     = offset[1] ? rdata[31:16] : rdata[15:0];
  assign sext  = ~ld_op[2];

  always_comb begin
    result = rdata;
    case (size_of(ld_op))
      SZ_B:    result = {{24{b[7] & sext}}, b};
      SZ_H:    result = {{16{h[15] & sext}}, h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: req/gnt/rvalid handshake, lane steering, pipeline stall.
// Optional MISALIGN_TRAP_EN adds misalign_o and suppresses misaligned accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       alu_data_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic [3:0]        ld_op_i,
  input  logic              mem_wren_i,
  input  logic              is_load_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              stall_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misalign_o
`endif
);

  state_e      state, state_n;
  size_e       sz;
  logic [1:0]  off;
  logic        access, bad, req, stall;
  logic [31:0] aligned;
  wr_lane_t    wl;

  assign off    = alu_data_i[1:0];
  assign sz     = size_of(ld_op_i);
  assign access = is_load_i | mem_wren_i;

`ifdef MISALIGN_TRAP_EN
  assign bad        = access & is_misaligned(sz, off);
  assign misalign_o = (state == IDLE) & bad & ~rst_i;
`else
  assign bad = 1'b0;
`endif

  load_align u_align (
    .rdata  (dmem_rdata_i),
    .offset (off),
    .ld_op  (ld_op_i),
    .result (aligned)
  );

  // Misaligned halves/words silently drop the low address bits.
  always_comb begin
    wl = '0;
    case (sz)
      SZ_B: begin
        wl.be    = 4'b0001 << off;
        wl.wdata = {4{st_data_i[7:0]}};
      end
      SZ_H: begin
        wl.be    = off[1] ? 4'b1100 : 4'b0011;
        wl.wdata = {2{st_data_i[15:0]}};
      end
      default: begin
        wl.be    = 4'b1111;
        wl.wdata = st_data_i;
      end
    endcase
  end

  always_comb begin
    state_n = state;
    req     = 1'b0;
    stall   = 1'b0;
    case (state)
      IDLE: if (access && !bad) begin
        req   = 1'b1;
        stall = 1'b1;
        if (dmem_gnt_i) state_n = is_load_i ? WAIT_RD : DONE;
      end
      WAIT_RD: begin
        stall = 1'b1;
        if (dmem_rvalid_i) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (rst_i) begin
      req   = 1'b0;
      stall = 1'b0;
    end
  end

  assign dmem_req_o   = req;
  assign dmem_we_o    = req & ~is_load_i;
  assign dmem_addr_o  = req ? {alu_data_i[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_be_o    = req ? wl.be : '0;
  assign dmem_wdata_o = req ? wl.wdata : '0;
  assign stall_o      = stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      ld_data_o <= '0;
    end else begin
      state <= state_n;
      if (state == WAIT_RD && dmem_rvalid_i) ld_data_o <= aligned;
`ifdef MISALIGN_TRAP_EN
      else if (state == IDLE && bad && is_load_i) ld_data_o <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + randomized bench for mem_access_unit against a byte-lane arithmetic model.
module tb_mem_access_unit;

  localparam logic [3:0] LD_B  = 4'b0000;
  localparam logic [3:0] LD_H  = 4'b0001;
  localparam logic [3:0] LD_W  = 4'b0010;
  localparam logic [3:0] LD_BU = 4'b0100;
  localparam logic [3:0] LD_HU = 4'b0101;

  logic        clk = 0;
  logic        rst;
  logic [31:0] alu, st, rdata;
  logic [3:0]  op;
  logic        wren, isld, gnt, rvalid;
  logic        req, we, stall;
  logic [31:0] addr, wdata, ld_data;
  logic [3:0]  be;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_ld = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .alu_data_i    (alu),
    .st_data_i     (st),
    .ld_op_i       (op),
    .mem_wren_i    (wren),
    .is_load_i     (isld),
    .dmem_req_o    (req),
    .dmem_we_o     (we),
    .dmem_addr_o   (addr),
    .dmem_be_o     (be),
    .dmem_wdata_o  (wdata),
    .dmem_gnt_i    (gnt),
    .dmem_rvalid_i (rvalid),
    .dmem_rdata_i  (rdata),
    .ld_data_o     (ld_data),
    .stall_o       (stall)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_o    (misalign)
`endif
  );

  // ---- reference model: access size in bytes, then plain shift/mask arithmetic
  function automatic int sz_bytes(input logic [3:0] o);
    if (o == 4'b0000 || o == 4'b0100) return 1;
    if (o == 4'b0001 || o == 4'b0101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_be(input logic [3:0] o, input logic [31:0] a);
    int off = int'(a % 4);
    case (sz_bytes(o))
      1:       return 32'(1 << off);
      2:       return 32'(3 << ((off / 2) * 2));
      default: return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] ref_wd(input logic [3:0] o, input logic [31:0] s);
    case (sz_bytes(o))
      1:       return (s & 32'hFF) * 32'h01010101;
      2:       return (s & 32'hFFFF) * 32'h00010001;
      default: return s;
    endcase
  endfunction

  function automatic logic [31:0] ref_ld(input logic [31:0] r, input logic [31:0] a,
                                         input logic [3:0] o);
    int          off = int'(a % 4);
    logic [31:0] v;
    case (sz_bytes(o))
      1: begin
        v = (r >> (8 * off)) & 32'hFF;
        if (!o[2] && v > 32'd127) v = v | 32'hFFFFFF00;
      end
      2: begin
        v = (r >> (16 * (off / 2))) & 32'hFFFF;
        if (!o[2] && v > 32'd32767) v = v | 32'hFFFF0000;
      end
      default: v = r;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One instruction through IDLE(+gnt wait) / WAIT_RD / DONE, checking every cycle.
  task automatic run_txn(input string tag, input logic [31:0] a, input logic [31:0] sd,
                         input logic [3:0] o, input logic wr, input logic ld,
                         input int gd, input int rdly, input logic [31:0] rdat);
    logic store = wr & ~ld;
    @(negedge clk);
    alu = a; st = sd; op = o; wren = wr; isld = ld; rvalid = 0; rdata = $urandom;
    for (int k = 0; k <= gd; k++) begin
      gnt = (k == gd);
      #1;
      if (k == 0) chk({tag, ".hold_ld"}, ld_data, exp_ld);
      chk({tag, ".req"},   32'(req),   1);
      chk({tag, ".stall"}, 32'(stall), 1);
      chk({tag, ".addr"},  addr,       a & ~32'd3);
      chk({tag, ".we"},    32'(we),    32'(store));
      if (store) begin
        chk({tag, ".be"},    32'(be), ref_be(o, a));
        chk({tag, ".wdata"}, wdata,   ref_wd(o, sd));
      end
      @(negedge clk);
    end
    gnt = 0;
    if (ld) begin
      for (int k = 1; k <= rdly; k++) begin
        rvalid = (k == rdly);
        rdata  = (k == rdly) ? rdat : $urandom;
        #1;
        chk({tag, ".rd_req"},   32'(req),   0);
        chk({tag, ".rd_stall"}, 32'(stall), 1);
        @(negedge clk);
      end
      rvalid = 0;
    end
    // DONE: stray handshakes here must be ignored
    gnt = 1'($urandom); rvalid = 1'($urandom); rdata = $urandom;
    #1;
    chk({tag, ".done_stall"}, 32'(stall), 0);
    chk({tag, ".done_req"},   32'(req),   0);
    if (ld) begin
      exp_ld = ref_ld(rdat, a, o);
      chk({tag, ".ld_data"}, ld_data, exp_ld);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      wren = 0; isld = 0; alu = $urandom; op = 4'($urandom);
      gnt = 1'($urandom); rvalid = 1'($urandom); rdata = $urandom;
      #1;
      chk("nomem.req",   32'(req),   0);
      chk("nomem.stall", 32'(stall), 0);
      chk("nomem.ld",    ld_data,    exp_ld);
    end
    @(negedge clk);
    gnt = 0; rvalid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ops [6];
    logic [31:0] ra;
    int          kind;
    ops[0] = LD_B; ops[1] = LD_H; ops[2] = LD_W; ops[3] = LD_BU; ops[4] = LD_HU; ops[5] = 4'b1011;

    // reset with a pending load on the inputs: everything must stay quiet
    rst = 1; alu = 32'h100; st = 0; op = LD_W; wren = 0; isld = 1;
    gnt = 1; rvalid = 1; rdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.req",   32'(req),   0);
    chk("rst.stall", 32'(stall), 0);
    chk("rst.ld",    ld_data,    0);
    @(negedge clk);
    rst = 0; isld = 0; gnt = 0; rvalid = 0;

    run_txn("sw",  32'h104, 32'hDEADBEEF, LD_W, 1, 0, 0, 0, 0);
    run_txn("sb",  32'h203, 32'h000000A5, LD_B, 1, 0, 3, 0, 0);
    run_txn("lb",  32'h102, 0, LD_B,  0, 1, 0, 2, 32'h0080FF00);
    chk("lb.value", exp_ld, 32'hFFFFFF80);
    run_txn("lbu", 32'h102, 0, LD_BU, 0, 1, 1, 2, 32'h0080FF00);
    chk("lbu.value", exp_ld, 32'h00000080);
    run_txn("lh",  32'h102, 0, LD_H,  0, 1, 0, 1, 32'h80011234);
    chk("lh.value", exp_ld, 32'hFFFF8001);
    run_txn("lhu", 32'h102, 0, LD_HU, 0, 1, 2, 3, 32'h80011234);
    chk("lhu.value", exp_ld, 32'h00008001);
    run_txn("both", 32'h300, 32'h12345678, LD_W, 1, 1, 1, 1, 32'hCAFEF00D);
    idle_cycles(4);

    // reset while waiting for read data; the late rvalid must not land
    @(negedge clk);
    alu = 32'h100; op = LD_W; isld = 1; wren = 0; gnt = 1;
    @(negedge clk);
    gnt = 0;
    #1 chk("rstw.wait_stall", 32'(stall), 1);
    rst = 1;
    #1 chk("rstw.stall_in_rst", 32'(stall), 0);
    @(negedge clk);
    rst = 0; isld = 0; rvalid = 1; rdata = 32'h5A5A5A5A;
    #1;
    chk("rstw.ld",    ld_data,    0);
    chk("rstw.stall", 32'(stall), 0);
    @(negedge clk);
    rvalid = 0;
    #1;
    chk("rstw.ld_after", ld_data,    0);
    chk("rstw.req",      32'(req),   0);
    exp_ld = 0;
    run_txn("post_rst", 32'h0, 32'h11223344, LD_W, 1, 0, 0, 0, 0);

`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    alu = 32'h101; op = LD_W; isld = 1; wren = 0; gnt = 1;
    #1;
    chk("mis.flag",  32'(misalign), 1);
    chk("mis.req",   32'(req),      0);
    chk("mis.stall", 32'(stall),    0);
    @(negedge clk);
    isld = 0; gnt = 0;
    #1 chk("mis.ld", ld_data, 0);
    exp_ld = 0;
`endif

    for (int i = 0; i < 40; i++) begin
      logic [3:0] o;
      o    = (i % 7 == 6) ? 4'($urandom) : ops[$urandom_range(0, 5)];
      ra   = $urandom;
`ifdef MISALIGN_TRAP_EN
      ra   = ra & ~32'(sz_bytes(o) - 1);
`endif
      kind = $urandom_range(0, 3);
      case (kind)
        0: run_txn("rnd_ld", ra, $urandom, o, 0, 1, $urandom_range(0, 3),
                   $urandom_range(1, 3), $urandom);
        1: run_txn("rnd_st", ra, $urandom, o, 1, 0, $urandom_range(0, 3), 0, 0);
        2: run_txn("rnd_both", ra, $urandom, o, 1, 1, $urandom_range(0, 2),
                   $urandom_range(1, 3), $urandom);
        default: idle_cycles($urandom_range(1, 3));
      endcase
    end
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
